lfsr_draw: RTL
==============

# lfsr_draw

Parametrised Fibonacci LFSR with a request/acknowledge draw port that returns uniformly distributed values in [0, RANGE-1] by rejection sampling. The LFSR width, tap mask, seed and output range are all parameters. The LFSR runs freely while `enable` is high, so player timing adds entropy between draws. The block supplies reel-stop indices to the slot-machine reel controller and generalises the fixed 4-bit feedback register.

## Interface
Parameters:
- `WIDTH`, 16: LFSR length in bits, 4..32.
- `TAPS`, 16'hB400: feedback mask of WIDTH bits; bit i set means `state[i]` feeds the XNOR.
- `SEED`, 0: reset and substitute value, WIDTH bits; must not be all-ones.
- `OUT_W`, 4: draw value width, must be ≤ WIDTH.
- `RANGE`, 10: number of legal values; 2^(OUT_W-1) < RANGE ≤ 2^OUT_W.
- `MAX_TRIES`, 8: rejected candidates allowed before fallback, ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  free-run stepping while the FSM is IDLE or HOLD.
- `seed_load`  in  1  load `seed_in` into the LFSR and abort any draw.
- `seed_in`  in  WIDTH  seed value.
- `req`  in  1  draw request; accepted when `req & ready`.
- `ready`  out  1  high in IDLE.
- `valid`  out  1  draw result available, held until acknowledged.
- `value`  out  OUT_W  draw result, always < RANGE while `valid` is high.
- `fallback`  out  1  qualifies `value`; set when the result came from the fallback path.
- `ack`  in  1  consumer accepts the result; only meaningful while `valid` is high.
- `lfsr_state`  out  WIDTH  current LFSR register.

## Operation
- Step function: `fb = ~^(state & TAPS)` (XNOR). Next state is `{state[WIDTH-2:0], fb}`. All-ones is the only lockup state.
- Seed guard: when `seed_in` is all-ones, `SEED` is loaded instead.
- Edge priority: `reset` low > `seed_load` > FSM action.
- Reset and `seed_load` both do the following:
  - state ← `SEED` on reset, or the guarded `seed_in` on `seed_load`.
  - FSM ← IDLE, `valid` = 0, `fallback` = 0, `value` = 0, try counter = 0.
- Reset values: `ready` = 1, `valid` = 0, `value` = 0, `fallback` = 0, `lfsr_state` = `SEED`.
- FSM states:
  - IDLE: step the LFSR if `enable` is high. If `req` is high, go to DRAW and clear the try counter.
  - DRAW: step the LFSR on every edge regardless of `enable`. The candidate `c` is the low OUT_W bits of the *new* state.
    - If `c < RANGE`: `value` ← `c`, `fallback` ← 0, go to HOLD.
    - Otherwise, if try counter + 1 == `MAX_TRIES`: `value` ← `c - RANGE`, `fallback` ← 1, go to HOLD. This result is always in range by the RANGE constraint.
    - Otherwise: increment the try counter and stay in DRAW.
  - HOLD: `valid` = 1. `value` and `fallback` are stable. Step the LFSR if `enable` is high. If `ack` is high, go to IDLE.
- `req` outside IDLE and `ack` outside HOLD are ignored.
- The try counter is ceil(log2(MAX_TRIES+1)) bits wide. The `c - RANGE` subtraction is OUT_W bits and cannot underflow because `c ≥ RANGE`.

## Timing
- `ready`, `valid`, `value`, `fallback` and `lfsr_state` are all registered; there are no combinational input-to-output paths.
- Request accepted at edge E0: `ready` = 0 after E0.
- Best case: `valid` = 1 after E1, a latency of 2 edges from request.
- Worst case: `valid` = 1 after E(MAX_TRIES), i.e. MAX_TRIES+1 edges.
- `ack` sampled at edge Ea while `valid` is high: `valid` = 0 and `ready` = 1 after Ea.
  - A new `req` is acceptable from edge Ea+1 onward.
  - Minimum draw-to-draw spacing is 3 cycles.
- `seed_load` or reset during DRAW or HOLD: the result is discarded and there is no `valid` pulse. `ready` = 1 on the next cycle.
- Period: with maximal-length TAPS the sequence is 2^WIDTH − 1 states, excluding all-ones.

## Test plan
- Step sequence: WIDTH=4, TAPS=4'b1100, SEED=0, `enable` = 1 from reset.
  - Required `lfsr_state`: 0,1,3,7,E,D,B,6,C,9,2,5,A,4,8,0 (period 15).
  - 4'hF never appears.
- Direct accept: OUT_W=4, RANGE=10, MAX_TRIES=2, after reset, `req` for one cycle.
  - After 2 edges: `valid` = 1, `value` = 1, `fallback` = 0.
  - `value` holds until `ack`; `ready` = 1 the edge after `ack`.
- Rejection: `seed_load` with `seed_in` = 4'h6, then `req`.
  - Candidate C (12) is rejected, then 9 is accepted.
  - `valid` after 3 edges, `value` = 9, `fallback` = 0.
- Fallback: `seed_in` = 4'h7, then `req`.
  - Candidates E and D are both rejected.
  - `value` = 3, `fallback` = 1, `valid` after 3 edges.
- Seed guard and abort:
  - `seed_in` = 4'hF gives `lfsr_state` = 0.
  - `seed_load` asserted during HOLD: `valid` drops on the next edge with no `ack` needed, and `ready` = 1.
- Reset mid-DRAW and stray handshakes:
  - `reset` low during DRAW: all outputs return to their reset values on the next edge.
  - `ack` in IDLE and `req` in HOLD have no effect.

Source files
------------

// File: rtl/lfsr_draw.sv
// Fibonacci XNOR LFSR with a req/ack draw port returning uniform values in [0, RANGE-1]
// by rejection sampling, with a bounded-retry fallback path.
`timescale 1ns/1ps
module lfsr_draw #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0]   SEED      = '0,
    parameter int                 OUT_W     = 4,
    parameter int                 RANGE     = 10,
    parameter int                 MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             ready,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic             fallback,
    input  logic             ack,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);
    localparam logic [OUT_W-1:0] RANGE_V  = RANGE_X[OUT_W-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    // XNOR feedback keeps all-zeros legal; all-ones is the lockup state.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ~^(s & TAPS);
        return {s[WIDTH-2:0], fb};
    endfunction

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   lfsr_r, lfsr_s;
    logic [TRY_W-1:0]   try_r, try_s;
    logic [OUT_W-1:0]   value_r, value_s;
    logic               fallback_r, fallback_s;
    logic               ready_r, ready_s;
    logic               valid_r, valid_s;
    logic [WIDTH-1:0]   stepped_s;
    logic [OUT_W-1:0]   cand_s;

    assign stepped_s = lfsr_step(lfsr_r);
    assign cand_s    = stepped_s[OUT_W-1:0];

    // Next-state, LFSR stepping and draw result selection.
    always_comb begin
        state_s    = state_r;
        lfsr_s     = lfsr_r;
        try_s      = try_r;
        value_s    = value_r;
        fallback_s = fallback_r;
        if (seed_load) begin
            state_s    = IDLE;
            lfsr_s     = (&seed_in) ? SEED : seed_in;
            try_s      = '0;
            value_s    = '0;
            fallback_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable) lfsr_s = stepped_s;
                    else        lfsr_s = lfsr_r;
                    if (req) begin
                        state_s = DRAW;
                        try_s   = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DRAW: begin
                    lfsr_s = stepped_s;
                    if ({1'b0, cand_s} < RANGE_X) begin
                        value_s    = cand_s;
                        fallback_s = 1'b0;
                        state_s    = HOLD;
                    end else if (try_r == LAST_TRY) begin
                        // cand >= RANGE > 2^(OUT_W-1), so the difference is already in range
                        value_s    = cand_s - RANGE_V;
                        fallback_s = 1'b1;
                        state_s    = HOLD;
                    end else begin
                        try_s   = try_r + TRY_W'(1);
                        state_s = DRAW;
                    end
                end
                HOLD: begin
                    if (enable) lfsr_s = stepped_s;
                    else        lfsr_s = lfsr_r;
                    if (ack) state_s = IDLE;
                    else     state_s = HOLD;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        ready_s = (state_s == IDLE);
        valid_s = (state_s == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            lfsr_r     <= SEED;
            try_r      <= '0;
            value_r    <= '0;
            fallback_r <= 1'b0;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            lfsr_r     <= lfsr_s;
            try_r      <= try_s;
            value_r    <= value_s;
            fallback_r <= fallback_s;
            ready_r    <= ready_s;
            valid_r    <= valid_s;
        end
    end

    assign ready      = ready_r;
    assign valid      = valid_r;
    assign value      = value_r;
    assign fallback   = fallback_r;
    assign lfsr_state = lfsr_r;

endmodule
